// File: rtl/stp_pkg.sv
// rtl/stp_pkg.sv - shared state encoding and width default for the serial_to_parallel block
package stp_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // PAR is only entered when SERIAL_TO_PARALLEL_PARITY_EN is defined
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } stp_state_t;

endpackage

// File: rtl/stp_shift_reg.sv
// rtl/stp_shift_reg.sv - load-enabled serial shift register with selectable shift direction
module stp_shift_reg
  import stp_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] held;
  logic [WIDTH-1:0] shifted;

  // MSB-first streams enter at the LSB and move up; LSB-first streams enter at the MSB and move down
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {held[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
      assign shifted = {bit_in, held[WIDTH-1:1]};
    end
  endgenerate

  // q shows the word including the bit being sampled this cycle, so the final bit can be
  // handed to the output register on the same edge it is captured
  assign q = load_en ? shifted : held;

  // register the shifted word; reset and clear both discard any partial contents
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
    end else if (clr) begin
      held <= '0;
    end else if (load_en) begin
      held <= shifted;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - serial bit stream to parallel word assembler; SERIAL_TO_PARALLEL_PARITY_EN adds an even-parity bit
module serial_to_parallel
  import stp_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              serial_valid,
  output logic [DATA_W-1:0] parallel_out,
  output logic              out_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  stp_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] sr_word;
  logic              sr_load;
  logic              sr_clr;

  // data bits are only accepted while collecting a word; a missing strobe mid-word discards it
  assign sr_load = serial_valid && ((state == IDLE) || (state == SHIFT));
  assign sr_clr  = (state != IDLE) && !serial_valid;
  assign busy    = (state != IDLE);

  stp_shift_reg #(
    .WIDTH     (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .clr     (sr_clr),
    .load_en (sr_load),
    .bit_in  (serial_in),
    .q       (sr_word)
  );

  // word framing FSM with bit counter and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (serial_valid) begin
            bit_cnt <= CNT_W'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!serial_valid) begin
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            state     <= IDLE;
          end else if (bit_cnt == LAST_CNT) begin
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            bit_cnt <= CNT_W'(DATA_W);
            state   <= PAR;
`else
            parallel_out <= sr_word;
            out_valid    <= 1'b1;
            bit_cnt      <= '0;
            state        <= IDLE;
`endif
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        PAR: begin
          bit_cnt <= '0;
          state   <= IDLE;
          // even parity: data bits plus parity bit must hold an even number of ones
          if (!serial_valid || (^{sr_word, serial_in})) begin
            frame_err <= 1'b1;
          end else begin
            parallel_out <= sr_word;
            out_valid    <= 1'b1;
          end
        end
`endif
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = first received bit is MSB, 0 = first received bit is LSB.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, reset, synchronous, active-high.
REQ-005 Port serial_in, input, 1, serial data bit.
REQ-006 Port serial_valid, input, 1, bit strobe; serial_in is sampled on each edge where serial_valid=1.
REQ-007 Port parallel_out, output, DATA_W, last completed word.
REQ-008 Port out_valid, output, 1, one-cycle pulse, new word on parallel_out.
REQ-009 Port frame_err, output, 1, one-cycle pulse, word aborted or (with PARITY_EN) parity mismatch.
REQ-010 Port busy, output, 1, high while a word is partially received.

Function
REQ-011 States SHALL be IDLE, SHIFT and (PARITY_EN only) PAR; busy = (state != IDLE).
REQ-012 IDLE with serial_valid=1 SHALL capture bit 0 of a word, set bit_cnt=1, and go to SHIFT.
REQ-013 SHIFT with serial_valid=1 SHALL capture the next bit and increment bit_cnt.
REQ-014 When bit DATA_W-1 is captured, the block SHALL go to IDLE, or to PAR with PARITY_EN.
REQ-015 MSB_FIRST=1: shift left, new bit into LSB; MSB_FIRST=0: shift right, new bit into MSB.
REQ-016 On the edge after the final data bit (after the parity bit with PARITY_EN), parallel_out SHALL load the assembled word and out_valid SHALL be 1 for exactly one cycle.
REQ-017 parallel_out SHALL hold its value until the next completed word; aborted words SHALL never alter it.
REQ-018 In SHIFT or PAR, serial_valid=0 SHALL discard the partial word, pulse frame_err on the next cycle, return to IDLE, and clear bit_cnt.
REQ-019 Back-to-back: a bit with serial_valid=1 on the edge immediately following word completion SHALL be bit 0 of the next word, with no gap cycle required.
REQ-020 out_valid and frame_err SHALL never be asserted in the same cycle.
REQ-021 bit_cnt SHALL be $clog2(DATA_W+1) bits wide and never exceed DATA_W.

Reset
REQ-022 rst=1 at a clock edge SHALL force state=IDLE, bit_cnt=0, shift register=0, parallel_out=0, out_valid=0, frame_err=0, busy=0.
REQ-023 rst asserted mid-word SHALL discard the partial word without a frame_err pulse.
REQ-024 rst SHALL take precedence over serial_valid on the same edge.

Configuration
REQ-025 Macro SERIAL_TO_PARALLEL_PARITY_EN defined: one even-parity bit follows the data bits; on mismatch, frame_err pulses, out_valid stays 0, and parallel_out is unchanged.
REQ-026 Macro SERIAL_TO_PARALLEL_PARITY_EN undefined: the PAR state and parity logic are absent; words are exactly DATA_W bits.

Structure
REQ-027 A shared package stp_pkg SHALL hold the state enum typedef (IDLE/SHIFT/PAR) and the default DATA_W constant.
REQ-028 One sub-module, stp_shift_reg (parameterised width and direction, load-enable), SHALL implement the shift register; the FSM and counter live in the top module.

Verification
REQ-029 DATA_W=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles -> parallel_out=0xA5, out_valid high one cycle after the 8th bit, busy low afterwards.
REQ-030 MSB_FIRST=0, same bit stream -> parallel_out=0xA5 bit-reversed = 0xA5 (palindrome); repeat with 0x03 stream 1,1,0,0,0,0,0,0 -> parallel_out=0x03.
REQ-031 Two words 0x05 then 0x07 sent back-to-back with serial_valid held high 16 cycles -> out_valid pulses at cycle 9 (0x05) and cycle 17 (0x07).
REQ-032 serial_valid dropped after 4 bits of 0x04 -> frame_err one pulse, out_valid never asserted, parallel_out keeps its previous value (0x07).
REQ-033 rst=1 asserted after 3 bits -> all outputs 0 next cycle, no frame_err; a following full 0x3C word is received correctly.
REQ-034 SERIAL_TO_PARALLEL_PARITY_EN defined: 0xA5 with parity 0 -> out_valid and 0xA5; 0xA5 with parity 1 -> frame_err, parallel_out unchanged.
